// File: rtl/zip_rr_scheduler_pkg.sv
// Shared types and helpers for the round-robin IQ symbol packer.
package zip_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PACK = 1'b1
    } state_t;

    localparam int SYMS_PER_WORD = 4;

    // Keep only the top nibble of I and of Q: {I[15:12], Q[15:12]}.
    function automatic logic [7:0] zip_byte(input logic [31:0] d);
        return {d[31:28], d[15:12]};
    endfunction

endpackage

// File: rtl/zip_rr_scheduler_if.sv
// Stream bundle for the scheduler: NUM_CH narrow-IQ sources in, one packed word stream out.
interface zip_rr_scheduler_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = $clog2(NUM_CH);

    logic [NUM_CH*32-1:0] s_tdata;
    logic [NUM_CH-1:0]    s_tlast;
    logic [NUM_CH-1:0]    s_tvalid;
    logic [NUM_CH-1:0]    s_tready;

    logic [31:0]          m_tdata;
    logic                 m_tlast;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [CH_W-1:0]      m_tdest;
    logic [2:0]           m_tcnt;

    // master: sources and sink around the scheduler
    modport master (
        output s_tdata, s_tlast, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tlast, m_tvalid, m_tdest, m_tcnt
    );

    // slave: the scheduler itself
    modport slave (
        input  s_tdata, s_tlast, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tlast, m_tvalid, m_tdest, m_tcnt
    );

endinterface

// File: rtl/zip_rr_scheduler_pick.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module zip_rr_pick #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    logic [CH_W-1:0] cand;

    // Scan from the farthest candidate back to the nearest so the nearest wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            cand = CH_W'((int'(ptr) + i) % NUM_CH);
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zip_rr_scheduler.sv
// Packet-granular round-robin sharing of a 4:1 IQ symbol packer among NUM_CH sources.
// Define ZIP_SCHED_STATS_EN to add per-channel packet/symbol counters (stat_sel/stat_pkts/stat_syms).
//
// state | meaning
// IDLE  | no grant held; pick next enabled requester after rr_ptr
// PACK  | packing the granted channel until its tlast word is accepted
module zip_rr_scheduler
    import zip_sched_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_en,
    input  logic [NUM_CH-1:0] cfg_mask,
    zip_rr_scheduler_if.slave bus,
`ifdef ZIP_SCHED_STATS_EN
    input  logic [CH_W-1:0]   stat_sel,
    output logic [31:0]       stat_pkts,
    output logic [31:0]       stat_syms,
`endif
    output logic              busy
);

    state_t            state;
    logic [CH_W-1:0]   rr_ptr;
    logic [NUM_CH-1:0] grant_oh;
    logic [1:0]        sym_cnt;
    logic [31:0]       acc;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] pick_grant;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;
    logic [31:0]       beat_data;
    logic              beat_valid;
    logic              beat_last;
    logic              rdy_ok;
    logic              beat;
    logic              word_done;
    logic              out_acc;
    logic [31:0]       acc_next;

    assign req = bus.s_tvalid & cfg_mask & {NUM_CH{cfg_en}};

    zip_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign beat_data  = bus.s_tdata[{bus.m_tdest, 5'd0} +: 32];
    assign beat_valid = |(bus.s_tvalid & grant_oh);
    assign beat_last  = |(bus.s_tlast & grant_oh);

    // Once the tlast word sits in the output register, stop taking beats so the
    // next packet of this channel cannot slip in before re-arbitration.
    assign rdy_ok    = (state == PACK) && (!bus.m_tvalid || (bus.m_tready && !bus.m_tlast));
    assign bus.s_tready = rdy_ok ? grant_oh : '0;

    assign beat      = rdy_ok && beat_valid;
    assign word_done = beat && ((sym_cnt == 2'(SYMS_PER_WORD - 1)) || beat_last);
    assign out_acc   = bus.m_tvalid && bus.m_tready;
    assign acc_next  = acc | ({24'd0, zip_byte(beat_data)} << {sym_cnt, 3'd0});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            rr_ptr       <= CH_W'(NUM_CH - 1);
            grant_oh     <= '0;
            sym_cnt      <= '0;
            acc          <= '0;
            bus.m_tdata  <= '0;
            bus.m_tlast  <= 1'b0;
            bus.m_tvalid <= 1'b0;
            bus.m_tdest  <= '0;
            bus.m_tcnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant_oh    <= pick_grant;
                        bus.m_tdest <= pick_idx;
                        state       <= PACK;
                        busy        <= 1'b1;
                    end
                end
                PACK: begin
                    if (out_acc) begin
                        bus.m_tvalid <= 1'b0;
                    end
                    if (beat) begin
                        if (word_done) begin
                            bus.m_tdata  <= acc_next;
                            bus.m_tcnt   <= {1'b0, sym_cnt} + 3'd1;
                            bus.m_tlast  <= beat_last;
                            bus.m_tvalid <= 1'b1;
                            acc          <= '0;
                            sym_cnt      <= '0;
                        end else begin
                            acc          <= acc_next;
                            sym_cnt      <= sym_cnt + 2'd1;
                        end
                    end
                    if (out_acc && bus.m_tlast) begin
                        rr_ptr <= bus.m_tdest;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ZIP_SCHED_STATS_EN
    logic [31:0] pkt_cnt [NUM_CH];
    logic [31:0] sym_tot [NUM_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pkt_cnt[c] <= '0;
                sym_tot[c] <= '0;
            end
            stat_pkts <= '0;
            stat_syms <= '0;
        end else begin
            if (beat) begin
                sym_tot[bus.m_tdest] <= sym_tot[bus.m_tdest] + 32'd1;
            end
            if (state == PACK && out_acc && bus.m_tlast) begin
                pkt_cnt[bus.m_tdest] <= pkt_cnt[bus.m_tdest] + 32'd1;
            end
            if (int'(stat_sel) < NUM_CH) begin
                stat_pkts <= pkt_cnt[stat_sel];
                stat_syms <= sym_tot[stat_sel];
            end else begin
                stat_pkts <= '0;
                stat_syms <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_zip_rr_scheduler.sv
// Randomized bench for zip_rr_scheduler against a packet/word-level reference model.
`timescale 1ns/1ps
module tb_zip_rr_scheduler;

    localparam int NUM_CH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_en;
    logic [3:0]  cfg_mask;
    logic        busy;
`ifdef ZIP_SCHED_STATS_EN
    logic [1:0]  stat_sel;
    logic [31:0] stat_pkts;
    logic [31:0] stat_syms;
`endif

    zip_rr_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    zip_rr_scheduler #(.NUM_CH(NUM_CH)) dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_en   (cfg_en),
        .cfg_mask (cfg_mask),
        .bus      (bus),
`ifdef ZIP_SCHED_STATS_EN
        .stat_sel (stat_sel),
        .stat_pkts(stat_pkts),
        .stat_syms(stat_syms),
`endif
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Source side: per-channel beat streams
    logic [31:0] q_data [NUM_CH][$];
    bit          q_last [NUM_CH][$];
    int          beat_idx [NUM_CH];
    int          beats_acc [NUM_CH];
    // Expected output words per channel, in order
    logic [31:0] e_word [NUM_CH][$];
    int          e_cnt  [NUM_CH][$];
    bit          e_last [NUM_CH][$];
    int          pkt_left [NUM_CH];
    int          model_ptr;
    bit          expect_new;
    int          pkts_done;
    int          dest_log [$];
    int          gap_pct;
    int          tready_mode;   // 0 always ready, 1 random, 2 held low
    logic [31:0] obs_word;
    int          obs_cnt;
    bit          obs_last;
    int          obs_dest;
    bit          prev_stall;
    logic [38:0] prev_m;

    // Next packet owner: first channel after the last winner that still has a packet and is enabled.
    function automatic int next_rr();
        for (int k = 1; k <= NUM_CH; k++) begin
            int c;
            c = (model_ptr + k) % NUM_CH;
            if (pkt_left[c] > 0 && cfg_mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit pending(input logic [3:0] m);
        for (int c = 0; c < NUM_CH; c++)
            if (m[c] && (e_word[c].size() > 0 || q_data[c].size() > 0)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_packet(input int c, input int len, input bit use_fixed, input logic [31:0] fixed);
        logic [31:0] w;
        logic [31:0] d;
        logic [7:0]  sym;
        w = '0;
        for (int k = 0; k < len; k++) begin
            d = use_fixed ? fixed : $urandom;
            q_data[c].push_back(d);
            q_last[c].push_back(k == len - 1);
            sym = {d[31:28], d[15:12]};
            w = w | (32'(sym) << (8 * (k % 4)));
            if (k % 4 == 3 || k == len - 1) begin
                e_word[c].push_back(w);
                e_cnt[c].push_back(k % 4 + 1);
                e_last[c].push_back(k == len - 1);
                w = '0;
            end
        end
        pkt_left[c]++;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        bus.s_tdata  = '0;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            q_data[c].delete();
            q_last[c].delete();
            e_word[c].delete();
            e_cnt[c].delete();
            e_last[c].delete();
            pkt_left[c]  = 0;
            beat_idx[c]  = 0;
            beats_acc[c] = 0;
        end
        model_ptr  = NUM_CH - 1;
        expect_new = 1'b1;
        prev_stall = 1'b0;
        pkts_done  = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: drive at negedge, observe 1 ns later, retire accepted beats after posedge.
    task automatic cycle();
        logic [NUM_CH*32-1:0] td;
        logic [NUM_CH-1:0]    tv;
        logic [NUM_CH-1:0]    tl;
        logic [NUM_CH-1:0]    acc_b;
        logic [38:0]          cur_m;
        logic [31:0]          w;
        logic [2:0]           c3;
        bit                   l;
        int                   d;
        int                   p;
        @(negedge clk);
        td = '0; tv = '0; tl = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (q_data[c].size() > 0) begin
                td[32*c +: 32] = q_data[c][0];
                tl[c] = q_last[c][0];
                tv[c] = (beat_idx[c] == 0) || ($urandom_range(99) >= gap_pct);
            end
        end
        bus.s_tdata  = td;
        bus.s_tvalid = tv;
        bus.s_tlast  = tl;
        bus.m_tready = (tready_mode == 0) ? 1'b1 : (tready_mode == 2) ? 1'b0 : ($urandom_range(99) < 60);
        #1;
        cur_m = {bus.m_tvalid, bus.m_tlast, bus.m_tdest, bus.m_tcnt, bus.m_tdata};
        checks++;
        if ($countones(bus.s_tready) > 1) begin
            errors++;
            $display("FAIL s_tready_onehot: got %b, expected at most one bit", bus.s_tready);
        end
        if (prev_stall) begin
            checks++;
            if (cur_m !== prev_m) begin
                errors++;
                $display("FAIL stall_stable: got %h, expected held %h", cur_m, prev_m);
            end
        end
        if (bus.m_tvalid && !bus.m_tready) begin
            checks++;
            if (bus.s_tready !== '0) begin
                errors++;
                $display("FAIL stall_s_tready: got %b, expected 0", bus.s_tready);
            end
        end
        if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
            d = int'(bus.m_tdest);
            if (expect_new) begin
                p = next_rr();
                checks++;
                if (d !== p) begin
                    errors++;
                    $display("FAIL grant_order: got tdest %0d, expected %0d", d, p);
                end
                expect_new = 1'b0;
            end
            dest_log.push_back(d);
            obs_word = bus.m_tdata; obs_cnt = int'(bus.m_tcnt); obs_last = bus.m_tlast; obs_dest = d;
            checks++;
            if (e_word[d].size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got word %h on tdest %0d, expected none", bus.m_tdata, d);
            end else begin
                w  = e_word[d].pop_front();
                c3 = 3'(e_cnt[d].pop_front());
                l  = e_last[d].pop_front();
                if ({bus.m_tdata, bus.m_tcnt, bus.m_tlast} !== {w, c3, l}) begin
                    errors++;
                    $display("FAIL word ch%0d: got data=%h cnt=%0d last=%b, expected data=%h cnt=%0d last=%b",
                             d, bus.m_tdata, bus.m_tcnt, bus.m_tlast, w, c3, l);
                end
                if (l) begin
                    expect_new = 1'b1;
                    model_ptr  = d;
                    pkt_left[d]--;
                    pkts_done++;
                end
            end
        end
        prev_stall = bus.m_tvalid && !bus.m_tready;
        prev_m     = cur_m;
        acc_b      = tv & bus.s_tready;
        @(posedge clk);
        for (int c = 0; c < NUM_CH; c++) begin
            if (acc_b[c]) begin
                beat_idx[c] = q_last[c][0] ? 0 : beat_idx[c] + 1;
                void'(q_data[c].pop_front());
                void'(q_last[c].pop_front());
                beats_acc[c]++;
            end
        end
    endtask

    task automatic drain(input logic [3:0] m, input int budget, input string name);
        int n;
        n = 0;
        while (pending(m) && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (pending(m)) begin
            errors++;
            $display("FAIL %s_timeout: got words still pending after %0d cycles, expected drained", name, budget);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks += 7;
        if (bus.m_tvalid !== 1'b0) begin errors++; $display("FAIL rst_m_tvalid: got %b expected 0", bus.m_tvalid); end
        if (bus.m_tlast  !== 1'b0) begin errors++; $display("FAIL rst_m_tlast: got %b expected 0", bus.m_tlast); end
        if (bus.m_tdata  !== '0)   begin errors++; $display("FAIL rst_m_tdata: got %h expected 0", bus.m_tdata); end
        if (bus.m_tdest  !== '0)   begin errors++; $display("FAIL rst_m_tdest: got %0d expected 0", bus.m_tdest); end
        if (bus.m_tcnt   !== '0)   begin errors++; $display("FAIL rst_m_tcnt: got %0d expected 0", bus.m_tcnt); end
        if (busy         !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        if (bus.s_tready !== '0)   begin errors++; $display("FAIL rst_s_tready: got %b expected 0", bus.s_tready); end
        reset_dut();
        // Requests with the scheduler disabled must not be granted
        cfg_en = 1'b0; cfg_mask = 4'hF; tready_mode = 0; gap_pct = 0;
        add_packet(1, 3, 1'b0, '0);
        repeat (6) cycle();
        #1;
        checks++;
        if (busy !== 1'b0 || beats_acc[1] != 0) begin
            errors++;
            $display("FAIL disabled_grant: got busy=%b beats=%0d, expected busy=0 beats=0", busy, beats_acc[1]);
        end
        reset_dut();
    endtask

    task automatic test_single();
        cfg_en = 1'b1; cfg_mask = 4'hF; tready_mode = 0; gap_pct = 0;
        add_packet(0, 4, 1'b1, 32'hA000_5000);
        drain(4'hF, 100, "single");
        checks++;
        if (obs_word !== 32'hA5A5_A5A5 || obs_cnt != 4 || obs_last !== 1'b1 || obs_dest != 0) begin
            errors++;
            $display("FAIL single_word: got %h cnt=%0d last=%b dest=%0d, expected a5a5a5a5 cnt=4 last=1 dest=0",
                     obs_word, obs_cnt, obs_last, obs_dest);
        end
`ifdef ZIP_SCHED_STATS_EN
        stat_sel = 2'd0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (stat_pkts !== 32'd1 || stat_syms !== 32'd4) begin
            errors++;
            $display("FAIL stats_ch0: got pkts=%0d syms=%0d, expected pkts=1 syms=4", stat_pkts, stat_syms);
        end
`endif
    endtask

    task automatic test_long_packet();
        add_packet(1, 6, 1'b0, '0);
        drain(4'hF, 100, "long");
        checks++;
        if (obs_cnt != 2 || obs_last !== 1'b1 || obs_word[31:16] !== 16'h0 || obs_dest != 1) begin
            errors++;
            $display("FAIL long_tail: got cnt=%0d last=%b upper=%h dest=%0d, expected cnt=2 last=1 upper=0000 dest=1",
                     obs_cnt, obs_last, obs_word[31:16], obs_dest);
        end
        add_packet(2, 5, 1'b0, '0);
        drain(4'hF, 100, "five");
        checks++;
        if (obs_cnt != 1 || obs_word[31:8] !== 24'h0) begin
            errors++;
            $display("FAIL five_tail: got cnt=%0d word=%h, expected cnt=1 upper lanes 0", obs_cnt, obs_word);
        end
    endtask

    task automatic test_round_robin();
        reset_dut();
        cfg_en = 1'b1; cfg_mask = 4'hF; tready_mode = 0; gap_pct = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++)
                add_packet(c, 1, 1'b0, '0);
        dest_log.delete();
        drain(4'hF, 200, "rr");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= dest_log.size() || dest_log[i] != i % NUM_CH) begin
                errors++;
                $display("FAIL rr_seq[%0d]: got %0d, expected %0d", i,
                         (i < dest_log.size()) ? dest_log[i] : -1, i % NUM_CH);
            end
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < NUM_CH; c++) beats_acc[c] = 0;
        tready_mode = 2; gap_pct = 0;
        add_packet(3, 8, 1'b0, '0);
        repeat (17) cycle();
        checks++;
        if (beats_acc[3] != 4) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats accepted while held, expected 4", beats_acc[3]);
        end
        tready_mode = 0;
        drain(4'hF, 100, "bp");
    endtask

    task automatic test_mask_and_enable();
        int n;
        int b0;
        reset_dut();
        cfg_en = 1'b1; cfg_mask = 4'b0101; tready_mode = 1; gap_pct = 20;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < NUM_CH; c++)
                add_packet(c, 6, 1'b0, '0);
        n = 0;
        while (pkts_done < 3 && n < 400) begin cycle(); n++; end
        n = 0;
        b0 = beats_acc[2];
        while (beats_acc[2] < b0 + 2 && n < 100) begin cycle(); n++; end
        cfg_en = 1'b0;
        n = 0;
        #1;
        while (busy !== 1'b0 && n < 300) begin cycle(); #1; n++; end
        checks++;
        if (pkts_done != 4 || e_word[0].size() != 0 || e_word[2].size() != 0) begin
            errors++;
            $display("FAIL en_drop_finish: got %0d packets, expected 4 with ch0/ch2 drained", pkts_done);
        end
        repeat (20) cycle();
        #1;
        checks++;
        if (busy !== 1'b0 || pkts_done != 4 || beats_acc[1] != 0 || beats_acc[3] != 0) begin
            errors++;
            $display("FAIL en_drop_idle: got busy=%b pkts=%0d ch1=%0d ch3=%0d, expected 0 4 0 0",
                     busy, pkts_done, beats_acc[1], beats_acc[3]);
        end
        reset_dut();
    endtask

    task automatic test_reset_mid_packet();
        int n;
        cfg_en = 1'b1; cfg_mask = 4'hF; tready_mode = 0; gap_pct = 0;
        add_packet(2, 6, 1'b0, '0);
        n = 0;
        while (beats_acc[2] < 2 && n < 50) begin cycle(); n++; end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.m_tvalid !== 1'b0 || busy !== 1'b0 || bus.s_tready !== '0) begin
            errors++;
            $display("FAIL mid_reset: got m_tvalid=%b busy=%b s_tready=%b, expected all 0",
                     bus.m_tvalid, busy, bus.s_tready);
        end
        reset_dut();
        add_packet(0, 3, 1'b0, '0);
        drain(4'hF, 100, "after_reset");
        checks++;
        if (obs_cnt != 3 || obs_dest != 0 || obs_word[31:24] !== 8'h0) begin
            errors++;
            $display("FAIL after_reset_word: got cnt=%0d dest=%0d word=%h, expected cnt=3 dest=0 lane3=0",
                     obs_cnt, obs_dest, obs_word);
        end
    endtask

    task automatic test_random();
        logic [3:0] m;
        for (int round = 0; round < 3; round++) begin
            reset_dut();
            m = 4'($urandom_range(15, 1));
            cfg_en = 1'b1; cfg_mask = m; tready_mode = 1; gap_pct = 25;
            for (int k = 0; k < 30; k++)
                add_packet($urandom_range(NUM_CH - 1), $urandom_range(9, 1), 1'b0, '0);
            drain(m, 6000, "random");
            for (int c = 0; c < NUM_CH; c++) begin
                if (!m[c]) begin
                    checks++;
                    if (beats_acc[c] != 0) begin
                        errors++;
                        $display("FAIL masked_ch%0d: got %0d beats accepted, expected 0", c, beats_acc[c]);
                    end
                end
            end
        end
        reset_dut();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        cfg_en       = 1'b0;
        cfg_mask     = 4'hF;
        bus.s_tdata  = '0;
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;
        tready_mode  = 0;
        gap_pct      = 0;
        pkts_done    = 0;
`ifdef ZIP_SCHED_STATS_EN
        stat_sel     = '0;
`endif
        test_reset();
        test_single();
        test_long_packet();
        test_round_robin();
        test_backpressure();
        test_mask_and_enable();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
